// File: rtl/idu_decode_stage.sv
// RV32I decode stage: registers one instruction per handshake, decodes fields and
// immediate, and reads the owned 32x32 register file with write-back bypass.
module idu_decode_stage #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic [31:0]     INSTR_IN,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic            WB_EN,
  input  logic [4:0]      WB_RD,
  input  logic [XLEN-1:0] WB_DATA,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [6:0]      OPCODE,
  output logic [4:0]      RD,
  output logic [2:0]      FUNCT3,
  output logic [6:0]      FUNCT7,
  output logic [4:0]      RS1_IDX,
  output logic [4:0]      RS2_IDX,
  output logic [XLEN-1:0] RS1_DATA,
  output logic [XLEN-1:0] RS2_DATA,
  output logic [XLEN-1:0] IMM,
  output logic [2:0]      INSTR_TYPE,
  output logic            ILLEGAL
);

  localparam logic [2:0] TYPE_R    = 3'd0;
  localparam logic [2:0] TYPE_I    = 3'd1;
  localparam logic [2:0] TYPE_S    = 3'd2;
  localparam logic [2:0] TYPE_B    = 3'd3;
  localparam logic [2:0] TYPE_U    = 3'd4;
  localparam logic [2:0] TYPE_J    = 3'd5;
  localparam logic [2:0] TYPE_NONE = 3'd7;

  logic [XLEN-1:0] rf_q [REG_COUNT];

  logic            out_valid_q, out_valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [2:0]      type_q, type_d;
  logic            illegal_q, illegal_d;

  logic            capture_s;
  logic            wb_live_s;
  logic [2:0]      dec_type_s;
  logic [XLEN-1:0] dec_imm_s;
  logic [XLEN-1:0] rd_op1_s, rd_op2_s;
  logic [4:0]      in_rs1_s, in_rs2_s;

  assign IN_READY  = !out_valid_q || OUT_READY;
  assign capture_s = IN_VALID && IN_READY;
  assign wb_live_s = WB_EN && (WB_RD != 5'd0);
  assign in_rs1_s  = INSTR_IN[19:15];
  assign in_rs2_s  = INSTR_IN[24:20];

  // Instruction format from the opcode; non-32-bit encodings are never valid.
  always_comb begin
    dec_type_s = TYPE_NONE;
    if (INSTR_IN[1:0] == 2'b11) begin
      case (INSTR_IN[6:0])
        7'b0110011:                                     dec_type_s = TYPE_R;
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec_type_s = TYPE_I;
        7'b0100011:                                     dec_type_s = TYPE_S;
        7'b1100011:                                     dec_type_s = TYPE_B;
        7'b0110111, 7'b0010111:                         dec_type_s = TYPE_U;
        7'b1101111:                                     dec_type_s = TYPE_J;
        default:                                        dec_type_s = TYPE_NONE;
      endcase
    end else begin
      dec_type_s = TYPE_NONE;
    end
  end

  // Sign-extended immediate, always sign-extended from instr[31].
  always_comb begin
    dec_imm_s = {XLEN{1'b0}};
    case (dec_type_s)
      TYPE_I:  dec_imm_s = {{20{INSTR_IN[31]}}, INSTR_IN[31:20]};
      TYPE_S:  dec_imm_s = {{20{INSTR_IN[31]}}, INSTR_IN[31:25], INSTR_IN[11:7]};
      TYPE_B:  dec_imm_s = {{19{INSTR_IN[31]}}, INSTR_IN[31], INSTR_IN[7],
                            INSTR_IN[30:25], INSTR_IN[11:8], 1'b0};
      TYPE_U:  dec_imm_s = {INSTR_IN[31:12], 12'h000};
      TYPE_J:  dec_imm_s = {{11{INSTR_IN[31]}}, INSTR_IN[31], INSTR_IN[19:12],
                            INSTR_IN[20], INSTR_IN[30:21], 1'b0};
      default: dec_imm_s = {XLEN{1'b0}};
    endcase
  end

  // Operand read with same-cycle write-back bypass; x0 always reads zero.
  always_comb begin
    rd_op1_s = {XLEN{1'b0}};
    rd_op2_s = {XLEN{1'b0}};
    if (in_rs1_s == 5'd0)                      rd_op1_s = {XLEN{1'b0}};
    else if (wb_live_s && (WB_RD == in_rs1_s)) rd_op1_s = WB_DATA;
    else                                       rd_op1_s = rf_q[in_rs1_s];
    if (in_rs2_s == 5'd0)                      rd_op2_s = {XLEN{1'b0}};
    else if (wb_live_s && (WB_RD == in_rs2_s)) rd_op2_s = WB_DATA;
    else                                       rd_op2_s = rf_q[in_rs2_s];
  end

  // Bundle next state: capture, drain, or hold with operand refresh on stall.
  always_comb begin
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    type_d      = type_q;
    illegal_d   = illegal_q;
    if (capture_s) begin
      out_valid_d = 1'b1;
      instr_d     = INSTR_IN;
      rs1_data_d  = rd_op1_s;
      rs2_data_d  = rd_op2_s;
      imm_d       = dec_imm_s;
      type_d      = dec_type_s;
      illegal_d   = (dec_type_s == TYPE_NONE);
    end else if (out_valid_q && OUT_READY) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q) begin
      if (wb_live_s && (WB_RD == instr_q[19:15])) rs1_data_d = WB_DATA;
      else                                        rs1_data_d = rs1_data_q;
      if (wb_live_s && (WB_RD == instr_q[24:20])) rs2_data_d = WB_DATA;
      else                                        rs2_data_d = rs2_data_q;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // Decode bundle registers.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      out_valid_q <= 1'b0;
      instr_q     <= 32'h0000_0000;
      rs1_data_q  <= {XLEN{1'b0}};
      rs2_data_q  <= {XLEN{1'b0}};
      imm_q       <= {XLEN{1'b0}};
      type_q      <= TYPE_NONE;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      type_q      <= type_d;
      illegal_q   <= illegal_d;
    end
  end

  // Register file; entry 0 is never written.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= {XLEN{1'b0}};
    end else if (wb_live_s) begin
      rf_q[WB_RD] <= WB_DATA;
    end
  end

  assign OUT_VALID  = out_valid_q;
  assign OPCODE     = instr_q[6:0];
  assign RD         = instr_q[11:7];
  assign FUNCT3     = instr_q[14:12];
  assign FUNCT7     = instr_q[31:25];
  assign RS1_IDX    = instr_q[19:15];
  assign RS2_IDX    = instr_q[24:20];
  assign RS1_DATA   = rs1_data_q;
  assign RS2_DATA   = rs2_data_q;
  assign IMM        = imm_q;
  assign INSTR_TYPE = type_q;
  assign ILLEGAL    = illegal_q;

endmodule

// File: tb/tb_idu_decode_stage.sv
// Self-checking bench for idu_decode_stage: directed table, handshake/bypass
// sequences, async reset, then random traffic against a behavioural model.
module tb_idu_decode_stage;

  logic        CLOCK, RESET;
  logic [31:0] INSTR_IN;
  logic        IN_VALID, IN_READY;
  logic        WB_EN;
  logic [4:0]  WB_RD;
  logic [31:0] WB_DATA;
  logic        OUT_VALID, OUT_READY;
  logic [6:0]  OPCODE, FUNCT7;
  logic [4:0]  RD, RS1_IDX, RS2_IDX;
  logic [2:0]  FUNCT3, INSTR_TYPE;
  logic [31:0] RS1_DATA, RS2_DATA, IMM;
  logic        ILLEGAL;

  idu_decode_stage dut (
    .CLOCK(CLOCK), .RESET(RESET), .INSTR_IN(INSTR_IN), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .WB_EN(WB_EN), .WB_RD(WB_RD), .WB_DATA(WB_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OPCODE(OPCODE), .RD(RD),
    .FUNCT3(FUNCT3), .FUNCT7(FUNCT7), .RS1_IDX(RS1_IDX), .RS2_IDX(RS2_IDX),
    .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA), .IMM(IMM),
    .INSTR_TYPE(INSTR_TYPE), .ILLEGAL(ILLEGAL)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // behavioural model state
  logic [31:0] m_rf [32];
  logic        m_valid;
  logic [31:0] m_instr, m_rs1d, m_rs2d, m_imm;
  logic [2:0]  m_type;
  logic        m_ill;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  typ;
    logic [31:0] imm;
    logic        ill;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode using masks and shifts on the raw word.
  function automatic void ref_dec(input logic [31:0] i, output logic [2:0] t,
                                  output logic [31:0] imm, output logic ill);
    logic [31:0] sgn;
    sgn = i[31] ? 32'hFFFF_FFFF : 32'h0000_0000;
    case (i[6:0])
      7'h33:                      t = 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73: t = 3'd1;
      7'h23:                      t = 3'd2;
      7'h63:                      t = 3'd3;
      7'h37, 7'h17:               t = 3'd4;
      7'h6F:                      t = 3'd5;
      default:                    t = 3'd7;
    endcase
    ill = (t == 3'd7);
    case (t)
      3'd1: imm = (sgn & 32'hFFFF_F800) | ((i >> 20) & 32'h7FF);
      3'd2: imm = (sgn & 32'hFFFF_F800) | (((i >> 25) & 32'h3F) << 5) | ((i >> 7) & 32'h1F);
      3'd3: imm = (sgn & 32'hFFFF_F000) | (((i >> 7) & 32'h1) << 11)
                | (((i >> 25) & 32'h3F) << 5) | (((i >> 8) & 32'hF) << 1);
      3'd4: imm = i & 32'hFFFF_F000;
      3'd5: imm = (sgn & 32'hFFF0_0000) | (i & 32'h000F_F000)
                | (((i >> 20) & 32'h1) << 11) | (((i >> 21) & 32'h3FF) << 1);
      default: imm = 32'h0000_0000;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) m_rf[k] = 32'h0;
    m_valid = 1'b0; m_instr = 32'h0; m_rs1d = 32'h0; m_rs2d = 32'h0;
    m_imm = 32'h0; m_type = 3'd7; m_ill = 1'b0;
  endtask

  function automatic logic [31:0] rd_op(input logic [4:0] idx, input logic we,
                                        input logic [4:0] wrd, input logic [31:0] wd);
    if (idx == 5'd0) return 32'h0;
    if (we && wrd == idx) return wd;
    return m_rf[idx];
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, {31'h0, OUT_VALID}, {31'h0, m_valid});
    chk({tag, ".fields"}, {OPCODE, RD, FUNCT3, RS1_IDX, RS2_IDX, FUNCT7},
        {m_instr[6:0], m_instr[11:7], m_instr[14:12], m_instr[19:15],
         m_instr[24:20], m_instr[31:25]});
    chk({tag, ".rs1_data"}, RS1_DATA, m_rs1d);
    chk({tag, ".rs2_data"}, RS2_DATA, m_rs2d);
    chk({tag, ".imm"}, IMM, m_imm);
    chk({tag, ".type"}, {29'h0, INSTR_TYPE}, {29'h0, m_type});
    chk({tag, ".illegal"}, {31'h0, ILLEGAL}, {31'h0, m_ill});
  endtask

  // One clock of stimulus: drive, check IN_READY, advance model, edge, compare.
  task automatic cycle(input string tag, input logic iv, input logic [31:0] ins,
                       input logic ordy, input logic we, input logic [4:0] wrd,
                       input logic [31:0] wd);
    logic cap;
    IN_VALID = iv; INSTR_IN = ins; OUT_READY = ordy;
    WB_EN = we; WB_RD = wrd; WB_DATA = wd;
    #1;
    chk({tag, ".in_ready"}, {31'h0, IN_READY}, {31'h0, (!m_valid || ordy)});
    cap = iv && (!m_valid || ordy);
    if (cap) begin
      m_valid = 1'b1;
      m_instr = ins;
      m_rs1d  = rd_op(ins[19:15], we, wrd, wd);
      m_rs2d  = rd_op(ins[24:20], we, wrd, wd);
      ref_dec(ins, m_type, m_imm, m_ill);
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end else if (m_valid) begin
      if (we && wrd != 5'd0 && wrd == m_instr[19:15]) m_rs1d = wd;
      if (we && wrd != 5'd0 && wrd == m_instr[24:20]) m_rs2d = wd;
    end
    if (we && wrd != 5'd0) m_rf[wrd] = wd;
    @(posedge CLOCK);
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [31:0] rins;
    logic [6:0]  ops [10];
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    tbl[0] = '{32'h0050_0093, 3'd1, 32'h0000_0005, 1'b0};  // addi x1,x0,5
    tbl[1] = '{32'hFE20_AE23, 3'd2, 32'hFFFF_FFFC, 1'b0};  // sw x2,-4(x1)
    tbl[2] = '{32'hFE00_0CE3, 3'd3, 32'hFFFF_FFF8, 1'b0};  // beq x0,x0,-8
    tbl[3] = '{32'h1234_52B7, 3'd4, 32'h1234_5000, 1'b0};  // lui x5,0x12345
    tbl[4] = '{32'h0000_1017, 3'd4, 32'h0000_1000, 1'b0};  // auipc x0,1
    tbl[5] = '{32'hFFDF_F0EF, 3'd5, 32'hFFFF_FFFC, 1'b0};  // jal x1,-4
    tbl[6] = '{32'hFFFF_FFFF, 3'd7, 32'h0000_0000, 1'b1};
    tbl[7] = '{32'h0000_0001, 3'd7, 32'h0000_0000, 1'b1};  // compressed
    tbl[8] = '{32'h0000_0073, 3'd1, 32'h0000_0000, 1'b0};  // ecall
    tbl[9] = '{32'h4020_81B3, 3'd0, 32'h0000_0000, 1'b0};  // sub x3,x1,x2

    RESET = 1'b0; IN_VALID = 1'b0; INSTR_IN = 32'h0; OUT_READY = 1'b0;
    WB_EN = 1'b0; WB_RD = 5'd0; WB_DATA = 32'h0;
    model_reset();
    @(posedge CLOCK); @(posedge CLOCK); #1;
    check_model("reset");
    @(negedge CLOCK); RESET = 1'b1;

    for (int v = 0; v < 10; v++) begin
      cycle("tbl", 1'b1, tbl[v].instr, 1'b1, 1'b0, 5'd0, 32'h0);
      chk("tbl.type_const", {29'h0, INSTR_TYPE}, {29'h0, tbl[v].typ});
      chk("tbl.imm_const", IMM, tbl[v].imm);
      chk("tbl.ill_const", {31'h0, ILLEGAL}, {31'h0, tbl[v].ill});
      chk("tbl.valid_const", {31'h0, OUT_VALID}, 32'h1);
    end

    // bypass: write x1 while capturing add x2,x1,x1
    cycle("bypass", 1'b1, 32'h0010_8133, 1'b1, 1'b1, 5'd1, 32'hDEAD_BEEF);
    chk("bypass.rs1", RS1_DATA, 32'hDEAD_BEEF);
    chk("bypass.rs2", RS2_DATA, 32'hDEAD_BEEF);

    // stall with refresh of held rs1, then capture with no bubble
    cycle("stall0", 1'b1, 32'h0000_8313, 1'b1, 1'b0, 5'd0, 32'h0);
    chk("stall0.rs1", RS1_DATA, 32'hDEAD_BEEF);
    cycle("stall1", 1'b1, 32'h0031_0233, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle("stall2", 1'b1, 32'h0031_0233, 1'b0, 1'b1, 5'd1, 32'h0000_0011);
    chk("stall2.rs1_refresh", RS1_DATA, 32'h0000_0011);
    chk("stall2.opcode_held", {25'h0, OPCODE}, 32'h13);
    cycle("stall3", 1'b1, 32'h0031_0233, 1'b0, 1'b0, 5'd0, 32'h0);
    cycle("release", 1'b1, 32'h0031_0233, 1'b1, 1'b0, 5'd0, 32'h0);
    chk("release.opcode", {25'h0, OPCODE}, 32'h33);
    chk("release.valid", {31'h0, OUT_VALID}, 32'h1);
    cycle("drain", 1'b0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);

    // x0 write ignored
    cycle("wbx0", 1'b0, 32'h0, 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    cycle("addx0", 1'b1, 32'h0000_01B3, 1'b1, 1'b0, 5'd0, 32'h0);
    chk("addx0.rs1", RS1_DATA, 32'h0);
    chk("addx0.rs2", RS2_DATA, 32'h0);

    // async reset mid-cycle while holding a valid bundle
    cycle("prerst", 1'b1, 32'h0000_8393, 1'b0, 1'b0, 5'd0, 32'h0);
    #2 RESET = 1'b0;
    #1;
    chk("async.out_valid", {31'h0, OUT_VALID}, 32'h0);
    chk("async.type", {29'h0, INSTR_TYPE}, 32'h7);
    chk("async.rs1", RS1_DATA, 32'h0);
    WB_EN = 1'b1; WB_RD = 5'd1; WB_DATA = 32'h5555_5555;
    model_reset();
    @(posedge CLOCK); #1;
    check_model("inrst");
    @(negedge CLOCK); RESET = 1'b1;
    cycle("postrst", 1'b1, 32'h0000_8413, 1'b1, 1'b0, 5'd0, 32'h0);
    chk("postrst.x1", RS1_DATA, 32'h0);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rins = $urandom;
      if ($urandom_range(0, 9) < 8) rins[6:0] = ops[$urandom_range(0, 9)];
      rins[19:15] = 5'($urandom_range(0, 7));
      rins[24:20] = 5'($urandom_range(0, 7));
      cycle("rand", 1'($urandom_range(0, 1)), rins, ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
